// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for seq_divider.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Controller side: issues operands, watches status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero short-circuits to DONE.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    // Partial remainder never reaches D between iterations, so WIDTH bits
    // hold it; the shifted trial value below carries the extra bit.
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_o;
    logic [WIDTH-1:0] rem_o;
    logic             dz_o;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             last;

    // One restoring step: shift {R,Q}, trial-subtract D, keep or restore.
    always_comb begin
        shifted = {rem_r, q_r[WIDTH-1]};
        trial   = shifted - {1'b0, d_r};
        r_next  = trial[WIDTH] ? shifted : trial;
        q_next  = {q_r[WIDTH-2:0], ~trial[WIDTH]};
        last    = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM, iteration datapath and registered result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem_r <= '0;
            q_r   <= '0;
            d_r   <= '0;
            cnt   <= '0;
            quo_o <= '0;
            rem_o <= '0;
            dz_o  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        q_r   <= bus.dividend;
                        d_r   <= bus.divisor;
                        rem_r <= '0;
                        cnt   <= '0;
                        if (bus.divisor != '0) begin
                            state <= RUN;
                        end else begin
                            quo_o <= '1;
                            rem_o <= bus.dividend;
                            dz_o  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem_r <= r_next[WIDTH-1:0];
                    q_r   <= q_next;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        quo_o <= q_next;
                        rem_o <= r_next[WIDTH-1:0];
                        dz_o  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status flags decode straight from the state register.
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quo_o;
    assign bus.remainder   = rem_o;
    assign bus.div_by_zero = dz_o;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): stimulus pushes expected
// results, an independent monitor pops and compares on every done pulse.
module tb_seq_divider;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare results on done; results must hold while busy.
    initial begin
        exp_t         e;
        logic [W-1:0] hq;
        logic [W-1:0] hr;
        logic         hdz;
        hq = '0; hr = '0; hdz = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hq = '0; hr = '0; hdz = 1'b0;
            end else if (bus.done) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: q=%0d r=%0d dz=%0d with nothing outstanding",
                             bus.quotient, bus.remainder, bus.div_by_zero);
                end else begin
                    e = sbq.pop_front();
                    if (bus.quotient !== e.q || bus.remainder !== e.r ||
                        bus.div_by_zero !== e.dz || bus.busy !== 1'b0) begin
                        bad++;
                        $display("FAIL result: got q=%0d r=%0d dz=%0d busy=%0d expected q=%0d r=%0d dz=%0d busy=0",
                                 bus.quotient, bus.remainder, bus.div_by_zero, bus.busy,
                                 e.q, e.r, e.dz);
                    end
                end
                hq = bus.quotient; hr = bus.remainder; hdz = bus.div_by_zero;
            end else if (bus.busy) begin
                total++;
                if (bus.quotient !== hq || bus.remainder !== hr || bus.div_by_zero !== hdz) begin
                    bad++;
                    $display("FAIL hold_while_busy: got q=%0d r=%0d dz=%0d expected q=%0d r=%0d dz=%0d",
                             bus.quotient, bus.remainder, bus.div_by_zero, hq, hr, hdz);
                end
            end
        end
    end

    // Call just after a negedge: present a start for one edge, log expectation.
    task automatic drive(input int a, input int b, input int eq, input int er, input int edz);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        e.q  = W'(eq);
        e.r  = W'(er);
        e.dz = edz[0];
        sbq.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Bounded wait for done; measures latency (negedges after accept) and busy
    // cycles. inj>0 fires an ignored 6/2 start at that negedge for one cycle.
    task automatic wait_done(input int exp_lat, input int exp_busy, input int inj);
        int lat;
        int bc;
        bit seen;
        lat = 0; bc = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (inj != 0 && lat == inj) begin
                bus.start = 1'b1; bus.dividend = 4'd6; bus.divisor = 4'd2;
            end else if (inj != 0 && lat == inj + 1) begin
                bus.start = 1'b0;
            end
            if (bus.busy) bc++;
            if (bus.done) seen = 1'b1;
        end
        chk("latency", lat, exp_lat);
        chk("busy_cycles", bc, exp_busy);
    endtask

    initial begin
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        drive(13, 3, 4, 1, 0);  wait_done(5, 4, 0);
        @(negedge clk); drive(15, 1, 15, 0, 0); wait_done(5, 4, 0);
        @(negedge clk); drive(2, 9, 0, 2, 0);   wait_done(5, 4, 0);
        @(negedge clk); drive(9, 9, 1, 0, 0);   wait_done(5, 4, 0);
        @(negedge clk); drive(7, 0, 15, 7, 1);  wait_done(1, 0, 0);
        @(negedge clk); drive(8, 2, 4, 0, 0);   wait_done(5, 4, 0);

        // Start during busy is ignored; then back-to-back start in DONE cycle
        @(negedge clk); drive(13, 3, 4, 1, 0); wait_done(5, 4, 2);
        drive(6, 2, 3, 0, 0); wait_done(5, 4, 0);

        // Divide-by-zero followed back-to-back by a real divide
        @(negedge clk); drive(11, 0, 15, 11, 1); wait_done(1, 0, 0);
        drive(11, 4, 2, 3, 0); wait_done(5, 4, 0);

        // Reset mid-RUN aborts with no done
        @(negedge clk); drive(14, 4, 3, 2, 0);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        void'(sbq.pop_back());
        #1 chk("midrun_reset_outputs",
               int'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_done_after_abort", int'(bus.done), 0);
        drive(14, 4, 3, 2, 0); wait_done(5, 4, 0);

        // Full operand sweep against a reference model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                if (b == 0) begin
                    drive(a, b, 15, a, 1); wait_done(1, 0, 0);
                end else begin
                    drive(a, b, a / b, a % b, 0); wait_done(5, 4, 0);
                end
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
